// File: rtl/gh_pkg.sv
// Shared types and constants for the note-chart sequencer and its lane interface.
package gh_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        WINDOW = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam int SCORE_W       = 16;
    localparam int NUM_LANES_DEF = 4;

endpackage

// File: rtl/note_window_gen_if.sv
// Lane-side bundle between the sequencer and the per-lane button controllers.
interface note_window_gen_if
    import gh_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF
);
    logic [NUM_LANES-1:0] hit_in;
    logic [NUM_LANES-1:0] window;
    logic [NUM_LANES-1:0] hit_ok;
    logic [NUM_LANES-1:0] miss;

    modport master (input hit_in, output window, hit_ok, miss);
    modport slave  (output hit_in, input window, hit_ok, miss);
endinterface

// File: rtl/note_pattern_mem.sv
// Note pattern storage: synchronous write, registered single-cycle read, no reset.
module note_pattern_mem #(
    parameter int DEPTH  = 64,
    parameter int WIDTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/note_window_gen.sv
// Note-chart sequencer: plays a stored pattern one beat at a time, opens per-lane
// hit windows and turns controller hit pulses into hit/miss pulses and a score.
//
// state  | meaning
// IDLE   | waiting for start; pattern memory writable
// FETCH  | one cycle; the current beat's entry is already on the read port
// WINDOW | hit windows open for WINDOW_CYCLES cycles
// GAP    | windows closed; wait out the rest of the beat
module note_window_gen
    import gh_pkg::*;
#(
    parameter int NUM_LANES     = NUM_LANES_DEF,
    parameter int PAT_DEPTH     = 64,
    parameter int BEAT_CYCLES   = 1000,
    parameter int WINDOW_CYCLES = 200,
    localparam int ADDR_W       = $clog2(PAT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pat_we,
    input  logic [ADDR_W-1:0]    pat_addr,
    input  logic [NUM_LANES-1:0] pat_data,
    input  logic [ADDR_W:0]      pat_len,
    input  logic                 start,
    input  logic                 abort,
    note_window_gen_if.master    lane,
    output logic [SCORE_W-1:0]   score,
    output logic                 busy,
    output logic                 done
);
    localparam int CNT_W = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(BEAT_CYCLES - WINDOW_CYCLES - 2);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(PAT_DEPTH);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     step_q, step_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [NUM_LANES-1:0]  window_q, window_d;
    logic [NUM_LANES-1:0]  hit_ok_q, hit_ok_d;
    logic [NUM_LANES-1:0]  miss_q, miss_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic                  done_q, done_d;

    logic [NUM_LANES-1:0]  hits;
    logic [NUM_LANES-1:0]  rd_data;
    logic [SCORE_W:0]      hit_cnt;
    logic [SCORE_W:0]      score_sum;
    logic [SCORE_W-1:0]    score_sat;

    // Addressed with step_d so the beat's entry is already registered during FETCH.
    note_pattern_mem #(
        .DEPTH  (PAT_DEPTH),
        .WIDTH  (NUM_LANES),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we      (pat_we && (state_q == IDLE)),
        .wr_addr (pat_addr),
        .wr_data (pat_data),
        .rd_addr (step_d),
        .rd_data (rd_data)
    );

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            hit_cnt = hit_cnt + (SCORE_W + 1)'(hits[i]);
        end
        score_sum = {1'b0, score_q} + hit_cnt;
        score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        len_d    = len_q;
        window_d = window_q;
        hit_ok_d = '0;
        miss_d   = '0;
        score_d  = score_q;
        done_d   = 1'b0;
        hits     = window_q & lane.hit_in;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    score_d = '0;
                    if (pat_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = (pat_len > DEPTH_L) ? DEPTH_L : pat_len;
                        step_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                window_d = rd_data;
                cnt_d    = WIN_LOAD;
                state_d  = WINDOW;
            end
            WINDOW: begin
                hit_ok_d = hits;
                score_d  = score_sat;
                window_d = window_q & ~hits;
                if (cnt_q == '0) begin
                    miss_d   = window_q & ~hits;
                    window_d = '0;
                    cnt_d    = GAP_LOAD;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if ({1'b0, step_q} == len_q - 1'b1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops everything in flight; the score earned so far stands.
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            window_d = '0;
            hit_ok_d = '0;
            miss_d   = '0;
            score_d  = score_q;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            step_q   <= '0;
            len_q    <= '0;
            window_q <= '0;
            hit_ok_q <= '0;
            miss_q   <= '0;
            score_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            len_q    <= len_d;
            window_q <= window_d;
            hit_ok_q <= hit_ok_d;
            miss_q   <= miss_d;
            score_q  <= score_d;
            done_q   <= done_d;
        end
    end

    assign lane.window = window_q;
    assign lane.hit_ok = hit_ok_q;
    assign lane.miss   = miss_q;
    assign score       = score_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
endmodule

// File: tb/tb_note_window_gen.sv
// Bench for note_window_gen: beat-offset reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_note_window_gen;
    localparam int LANES = 4;
    localparam int DEPTH = 64;
    localparam int BEAT  = 20;
    localparam int WIN   = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pat_we = 1'b0;
    logic [5:0]  pat_addr = '0;
    logic [3:0]  pat_data = '0;
    logic [6:0]  pat_len = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] score;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    note_window_gen_if #(.NUM_LANES(LANES)) lane_if ();

    note_window_gen #(
        .NUM_LANES     (LANES),
        .PAT_DEPTH     (DEPTH),
        .BEAT_CYCLES   (BEAT),
        .WINDOW_CYCLES (WIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pat_we   (pat_we),
        .pat_addr (pat_addr),
        .pat_data (pat_data),
        .pat_len  (pat_len),
        .start    (start),
        .abort    (abort),
        .lane     (lane_if.master),
        .score    (score),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Reference model: position within the run as a cycle offset from the first FETCH.
    logic        m_run = 1'b0;
    logic [3:0]  m_open = '0;
    logic [3:0]  e_hit_ok = '0;
    logic [3:0]  e_miss = '0;
    logic        e_done = 1'b0;
    logic [15:0] m_score = '0;
    int          m_k = 0;
    int          m_len = 0;
    logic [3:0]  m_pat [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] hits;
        logic       busy_pre;
        int         off;
        int         beat;
        int         tot;
        e_hit_ok = '0;
        e_miss   = '0;
        e_done   = 1'b0;
        if (!rst_n) begin
            m_run   = 1'b0;
            m_open  = '0;
            m_score = '0;
            m_k     = 0;
            return;
        end
        busy_pre = m_run;
        if (m_run) begin
            if (abort) begin
                m_run  = 1'b0;
                m_open = '0;
            end else begin
                off  = m_k % BEAT;
                beat = m_k / BEAT;
                hits = m_open & lane_if.hit_in;
                e_hit_ok = hits;
                tot = int'(m_score) + $countones(hits);
                m_score = (tot > 16'hFFFF) ? 16'hFFFF : 16'(tot);
                m_open = m_open & ~hits;
                if (off == WIN) begin
                    e_miss = m_open;
                    m_open = '0;
                end
                if (off == 0) m_open = m_pat[beat];
                if ((off == BEAT - 1) && (beat == m_len - 1)) begin
                    m_run  = 1'b0;
                    e_done = 1'b1;
                end
                m_k++;
            end
        end else if (start && !abort) begin
            m_score = '0;
            if (pat_len == 0) begin
                e_done = 1'b1;
            end else begin
                m_run = 1'b1;
                m_k   = 0;
                m_len = (int'(pat_len) > DEPTH) ? DEPTH : int'(pat_len);
            end
        end
        if (pat_we && !busy_pre) m_pat[pat_addr] = pat_data;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("window", lane_if.window, m_open);
        check("hit_ok", lane_if.hit_ok, e_hit_ok);
        check("miss",   lane_if.miss,   e_miss);
        check("done",   done,           e_done);
        check("busy",   busy,           m_run);
        check("score",  score,          m_score);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int a, input logic [3:0] d);
        pat_we   = 1'b1;
        pat_addr = 6'(a);
        pat_data = d;
        cyc(1);
        pat_we   = 1'b0;
    endtask

    // Returns mid-way through cycle 0 of the run (the first FETCH cycle).
    task automatic go(input int len);
        pat_len = 7'(len);
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
    endtask

    initial begin
        lane_if.hit_in = '0;
        cyc(3);
        check("rst_busy", busy, 1'b0);
        check("rst_score", score, 16'h0);
        check("rst_window", lane_if.window, 4'h0);
        rst_n = 1'b1;
        cyc(5);
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);

        // Basic hit then miss
        load(0, 4'b0001);
        load(1, 4'b0010);
        go(2);
        cyc(3);
        lane_if.hit_in = 4'b0001;
        cyc(1);
        lane_if.hit_in = '0;
        check("basic_hit_ok", lane_if.hit_ok, 4'b0001);
        check("basic_win_drop", lane_if.window, 4'b0000);
        cyc(21);
        check("basic_win1", lane_if.window, 4'b0010);
        check("basic_nomiss", lane_if.miss, 4'b0000);
        cyc(1);
        check("basic_miss1", lane_if.miss, 4'b0010);
        cyc(13);
        check("basic_done_early", done, 1'b0);
        check("basic_busy39", busy, 1'b1);
        cyc(1);
        check("basic_done40", done, 1'b1);
        check("basic_idle40", busy, 1'b0);
        check("basic_score", score, 16'd1);
        cyc(2);

        // Hit on last window cycle counts; hit just after close is ignored
        load(0, 4'b0100);
        load(1, 4'b1000);
        go(2);
        cyc(5);
        lane_if.hit_in = 4'b0100;
        cyc(1);
        lane_if.hit_in = '0;
        check("edge_hit_ok", lane_if.hit_ok, 4'b0100);
        check("edge_nomiss", lane_if.miss, 4'b0000);
        cyc(20);
        lane_if.hit_in = 4'b1000;
        check("late_miss", lane_if.miss, 4'b1000);
        cyc(1);
        lane_if.hit_in = '0;
        check("late_ignored", lane_if.hit_ok, 4'b0000);
        check("late_score", score, 16'd1);
        cyc(16);

        // Multi-lane hit, stray hit on a closed lane, rest beat
        load(0, 4'b1111);
        load(1, 4'b0000);
        go(2);
        cyc(2);
        lane_if.hit_in = 4'b1011;
        cyc(1);
        lane_if.hit_in = 4'b0001;
        check("multi_hit_ok", lane_if.hit_ok, 4'b1011);
        check("multi_score", score, 16'd3);
        check("multi_window", lane_if.window, 4'b0100);
        cyc(1);
        lane_if.hit_in = '0;
        check("stray_hit_ok", lane_if.hit_ok, 4'b0000);
        check("stray_score", score, 16'd3);
        cyc(2);
        check("multi_miss", lane_if.miss, 4'b0100);
        cyc(16);
        check("rest_window", lane_if.window, 4'b0000);
        cyc(21);

        // Abort mid-window keeps score, no miss/done
        load(0, 4'b0011);
        go(1);
        cyc(1);
        lane_if.hit_in = 4'b0001;
        cyc(1);
        lane_if.hit_in = '0;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("abort_window", lane_if.window, 4'b0000);
        check("abort_busy", busy, 1'b0);
        check("abort_score", score, 16'd1);
        cyc(3);
        check("abort_nomiss", lane_if.miss, 4'b0000);
        cyc(20);

        // start and abort together: abort wins
        pat_len = 7'd1;
        start = 1'b1;
        abort = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        check("startabort_busy", busy, 1'b0);
        check("startabort_score", score, 16'd1);

        // Zero-length start
        go(0);
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b0);
        check("len0_score", score, 16'd0);
        cyc(1);
        check("len0_done_off", done, 1'b0);

        // start and pat_we while busy are ignored
        load(0, 4'b0001);
        go(1);
        cyc(2);
        pat_len  = 7'd2;
        start    = 1'b1;
        pat_we   = 1'b1;
        pat_addr = 6'd0;
        pat_data = 4'b1000;
        cyc(1);
        start  = 1'b0;
        pat_we = 1'b0;
        cyc(17);
        check("busy_start_done", done, 1'b1);
        cyc(2);
        go(1);
        cyc(1);
        check("busy_we_ignored", lane_if.window, 4'b0001);
        cyc(21);

        // Score saturation
        load(0, 4'b1111);
        go(1);
        force dut.score_q = 16'hFFFE;
        m_score = 16'hFFFE;
        #1;
        release dut.score_q;
        cyc(2);
        lane_if.hit_in = 4'b0011;
        cyc(1);
        lane_if.hit_in = 4'b0100;
        check("sat_hit_ok1", lane_if.hit_ok, 4'b0011);
        check("sat_score1", score, 16'hFFFF);
        cyc(1);
        lane_if.hit_in = '0;
        check("sat_hit_ok2", lane_if.hit_ok, 4'b0100);
        check("sat_score2", score, 16'hFFFF);
        cyc(18);

        // Asynchronous reset in the middle of a window
        load(0, 4'b1111);
        go(1);
        cyc(1);
        lane_if.hit_in = 4'b0001;
        cyc(1);
        lane_if.hit_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_window", lane_if.window, 4'b0000);
        check("arst_hit_ok", lane_if.hit_ok, 4'b0000);
        check("arst_miss", lane_if.miss, 4'b0000);
        check("arst_busy", busy, 1'b0);
        check("arst_score", score, 16'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_window", lane_if.window, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
